// File: rtl/output_datapath.sv
// Output unloading stage: holds a 512-bit systolic result and streams it out LSB chunk first.
// Optional DONE_MATRIX_MULT_EN adds a registered last-chunk-delivered pulse.
module sh_counter #(
    parameter int                 CNT_W = 3,
    parameter logic [CNT_W-1:0]   MAX   = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && count != MAX)
            count <= count + CNT_W'(1);
    end

endmodule

module output_datapath #(
    parameter int DATA_W     = 64,
    parameter int NUM_CHUNKS = 8,
    parameter int CNT_W      = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_out,
    input  logic                         shift,
    input  logic                         src_ready,
    input  logic [DATA_W*NUM_CHUNKS-1:0] systolic_output,
    input  logic                         dest_valid,
`ifdef DONE_MATRIX_MULT_EN
    output logic                         done_matrix_mult,
`endif
    output logic [DATA_W-1:0]            final_data_out,
    output logic                         sh_count_done,
    output logic                         tx_two_done
);

    localparam int               IN_W = DATA_W * NUM_CHUNKS;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);

    logic [IN_W-1:0]   buffer_to_feeder;
    logic [IN_W-1:0]   feeder;
    logic [DATA_W-1:0] feeder_to_rv;
    logic [CNT_W-1:0]  count;
    logic              handshake;
    logic              shift_en;

    assign feeder_to_rv  = feeder[DATA_W-1:0];
    assign handshake     = dest_valid && src_ready;
    assign sh_count_done = (count == LAST);
    // Shifting stops once the last chunk sits at the bottom of the feeder.
    assign shift_en      = shift && !load_out && !sh_count_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            buffer_to_feeder <= '0;
        else if (load_out)
            buffer_to_feeder <= systolic_output;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            feeder <= '0;
        else if (load_out)
            feeder <= systolic_output;
        else if (shift_en)
            feeder <= feeder >> DATA_W;
    end

    sh_counter #(
        .CNT_W (CNT_W),
        .MAX   (LAST)
    ) sh_counter_output_datapath (
        .clk   (clk),
        .reset (reset),
        .clear (load_out),
        .inc   (shift_en),
        .count (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            final_data_out <= '0;
        else if (handshake)
            final_data_out <= feeder_to_rv;
    end

    // A shift or reload in the same cycle as a handshake leaves the flag low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tx_two_done <= 1'b0;
        else if (load_out || shift)
            tx_two_done <= 1'b0;
        else if (handshake)
            tx_two_done <= 1'b1;
    end

`ifdef DONE_MATRIX_MULT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            done_matrix_mult <= 1'b0;
        else
            done_matrix_mult <= handshake && sh_count_done;
    end
`endif

endmodule

// File: tb/tb_output_datapath.sv
// Bench for output_datapath: directed plan plus random traffic against a chunk-index model.
module tb_output_datapath;

    localparam int DW = 64;
    localparam int NC = 8;
    localparam int IW = DW * NC;

    logic          clk = 1'b0;
    logic          reset, load_out, shift, src_ready, dest_valid;
    logic [IW-1:0] sys;
    logic [DW-1:0] fdo;
    logic          scd, txd;
`ifdef DONE_MATRIX_MULT_EN
    logic          done;
`endif

    output_datapath dut (
        .clk             (clk),
        .reset           (reset),
        .load_out        (load_out),
        .shift           (shift),
        .src_ready       (src_ready),
        .systolic_output (sys),
        .dest_valid      (dest_valid),
`ifdef DONE_MATRIX_MULT_EN
        .done_matrix_mult(done),
`endif
        .final_data_out  (fdo),
        .sh_count_done   (scd),
        .tx_two_done     (txd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [IW-1:0] m_vec;
    int            m_idx;
    logic [DW-1:0] m_fdo;
    bit            m_tx;
    bit            m_done;

    function automatic logic [DW-1:0] m_chunk();
        return m_vec[DW*m_idx +: DW];
    endfunction

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_all();
        chk("final_data_out", fdo, m_fdo);
        chk("sh_count_done", 64'(scd), 64'(m_idx == NC - 1));
        chk("tx_two_done", 64'(txd), 64'(m_tx));
        chk("feeder_to_rv", dut.feeder_to_rv, m_chunk());
        chk("count", 64'(dut.sh_counter_output_datapath.count), 64'(m_idx));
`ifdef DONE_MATRIX_MULT_EN
        chk("done_matrix_mult", 64'(done), 64'(m_done));
`endif
    endtask

    task automatic model_reset();
        m_vec = '0; m_idx = 0; m_fdo = '0; m_tx = 0; m_done = 0;
    endtask

    task automatic model_step();
        bit hs;
        hs = dest_valid && src_ready;
        m_done = hs && (m_idx == NC - 1);
        if (hs) m_fdo = m_chunk();
        if (load_out) begin
            m_vec = sys;
            m_idx = 0;
        end else if (shift && m_idx < NC - 1) begin
            m_idx++;
        end
        if (load_out || shift) m_tx = 0;
        else if (hs) m_tx = 1;
    endtask

    task automatic cycle(bit l, bit s, bit dv, bit sr, logic [IW-1:0] d);
        @(negedge clk);
        load_out = l; shift = s; dest_valid = dv; src_ready = sr; sys = d;
        @(posedge clk);
        model_step();
        #1 check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        load_out = 0; shift = 0; dest_valid = 0; src_ready = 0;
        reset = 1;
        #2 model_reset();
        #1 check_all();
        @(negedge clk);
        reset = 0;
    endtask

    logic [IW-1:0] v1, v2, rv;
    logic [DW-1:0] exp_seq [7];

    initial begin
        v1 = 512'hDEADBEEFCAFEBABE_1122334455667788_99AABBCCDDEEF00D_123456789ABCDEF0_13579BDFDEADBEEF_2468ACE0FEDCBA98_0FEDCBA987654321_1122334455667788;
        exp_seq = '{64'h0FEDCBA987654321, 64'h2468ACE0FEDCBA98,
                    64'h13579BDFDEADBEEF, 64'h123456789ABCDEF0,
                    64'h99AABBCCDDEEF00D, 64'h1122334455667788,
                    64'hDEADBEEFCAFEBABE};
        reset = 1; load_out = 0; shift = 0; dest_valid = 0; src_ready = 0; sys = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 0;
        cycle(0, 0, 0, 0, '0);
        chk("reset_fdo", fdo, 64'h0);
        chk("reset_scd", 64'(scd), 64'h0);
        chk("reset_tx", 64'(txd), 64'h0);

        cycle(1, 0, 0, 0, v1);
        chk("load_buffer_lo", dut.buffer_to_feeder[DW-1:0], v1[DW-1:0]);
        chk("load_buffer_hi", dut.buffer_to_feeder[IW-1 -: DW], 64'hDEADBEEFCAFEBABE);
        chk("load_chunk0", dut.feeder_to_rv, 64'h1122334455667788);

        cycle(0, 0, 1, 0, '0);
        cycle(0, 0, 1, 1, '0);
        chk("hs0_fdo", fdo, 64'h1122334455667788);
        chk("hs0_tx", 64'(txd), 64'h1);

        for (int i = 0; i < 7; i++) begin
            cycle(0, 1, 0, 0, '0);
            cycle(0, 0, 1, 1, '0);
            chk($sformatf("round%0d_fdo", i + 1), fdo, exp_seq[i]);
        end
        chk("last_count", 64'(dut.sh_counter_output_datapath.count), 64'h7);
        chk("last_scd", 64'(scd), 64'h1);

        cycle(0, 1, 0, 0, '0);
        chk("extra_count", 64'(dut.sh_counter_output_datapath.count), 64'h7);
        chk("extra_chunk", dut.feeder_to_rv, 64'hDEADBEEFCAFEBABE);

        cycle(1, 0, 0, 0, v1);
        cycle(0, 1, 1, 1, '0);
        cycle(0, 1, 0, 0, '0);
        do_reset();
        for (int w = 0; w < IW / 32; w++) v2[32*w +: 32] = $urandom;
        cycle(1, 0, 0, 0, v2);
        chk("rst_count", 64'(dut.sh_counter_output_datapath.count), 64'h0);
        chk("rst_scd", 64'(scd), 64'h0);
        chk("rst_tx", 64'(txd), 64'h0);
        chk("rst_fdo", fdo, 64'h0);
        chk("rst_chunk0", dut.feeder_to_rv, v2[DW-1:0]);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                for (int w = 0; w < IW / 32; w++) rv[32*w +: 32] = $urandom;
                cycle($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rv);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
